// File: rtl/core_pkg.sv
// Shared sequencer types and constants for the core control path.
package core_pkg;

    // Sequencer control states. Encodings above FAULT are unused.
    typedef enum logic [2:0] {
        FETCH   = 3'd0,
        DECODE  = 3'd1,
        EXECUTE = 3'd2,
        HALTED  = 3'd3,
        FAULT   = 3'd4
    } seq_state_t;

    // Canonical NOP (addi x0, x0, 0) held in the IR out of reset.
    localparam logic [31:0] NOP_INSN   = 32'h0000_0013;

    // Sequential PC stride.
    localparam int          INSN_BYTES = 4;

    // A redirect target is unusable unless it is word aligned.
    function automatic logic misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Bounds instruction-fetch latency: counts consecutive un-acked FETCH
// cycles and flags the cycle in which the last allowed attempt is seen.
module fetch_watchdog #(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    input  logic count_en,
    input  logic clear,
    output logic expired
);

    localparam int             CW   = $clog2(ACK_TIMEOUT + 1);
    // count holds the number of earlier un-acked cycles, so the request is
    // in its final allowed cycle once count reaches ACK_TIMEOUT-1.
    localparam logic [CW-1:0]  LAST = CW'(ACK_TIMEOUT - 1);

    logic [CW-1:0] count;

    // Counter clears on ack / leaving FETCH and saturates at the limit.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count_en && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (count == LAST);

endmodule

// File: rtl/insn_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE sequencer. Owns PC and IR, runs the
// req/ack fetch handshake under a watchdog, and gates the regfile write
// strobe so each instruction writes exactly once.
module insn_sequencer
    import core_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = '0,
    parameter int              ACK_TIMEOUT = 255
) (
    input  logic            clock,
    input  logic            reset,
    output logic            insn_req,
    output logic [XLEN-1:0] insn_addr,
    input  logic            insn_ack,
    input  logic [XLEN-1:0] insn_rdata,
    output logic [XLEN-1:0] insn_reg,
    output logic [XLEN-1:0] pc,
    input  logic            exec_rd_enable_write,
    output logic            rd_write_strobe,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    input  logic            halt,
    output logic            halted,
    output logic            retire,
    output logic            fault
);

    seq_state_t      state;
    seq_state_t      state_nxt;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] ir_q;
    logic [XLEN-1:0] pc_seq;

    logic in_fetch;
    logic in_exec;
    logic ack_hit;
    logic bad_target;
    logic commit;
    logic wd_expired;

    assign in_fetch   = (state == FETCH);
    assign in_exec    = (state == EXECUTE);
    // Ack only means something while a fetch is outstanding.
    assign ack_hit    = in_fetch & insn_ack;
    assign bad_target = branch_taken & misaligned(branch_target[1:0]);
    // The instruction completes unless its redirect is unusable.
    assign commit     = in_exec & ~bad_target;
    // Wraps naturally at all-ones.
    assign pc_seq     = pc_q + XLEN'(INSN_BYTES);

    fetch_watchdog #(
        .ACK_TIMEOUT (ACK_TIMEOUT)
    ) u_watchdog (
        .clock    (clock),
        .reset    (reset),
        .count_en (in_fetch & ~insn_ack),
        .clear    (~in_fetch | insn_ack),
        .expired  (wd_expired)
    );

    // Next-state selection; an ack in the watchdog's last cycle wins.
    always_comb begin
        state_nxt = state;
        case (state)
            FETCH: begin
                if (insn_ack) begin
                    state_nxt = DECODE;
                end else if (wd_expired) begin
                    state_nxt = FAULT;
                end
            end
            DECODE: begin
                state_nxt = EXECUTE;
            end
            EXECUTE: begin
                if (bad_target) begin
                    state_nxt = FAULT;
                end else if (halt) begin
                    state_nxt = HALTED;
                end else begin
                    state_nxt = FETCH;
                end
            end
            HALTED: begin
                if (!halt) begin
                    state_nxt = FETCH;
                end
            end
            FAULT: begin
                state_nxt = FAULT;
            end
            default: begin
                state_nxt = FAULT;
            end
        endcase
    end

    // State register; FAULT is left only through reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // PC advances (or redirects) on the edge that ends a committed EXECUTE.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else if (commit) begin
            pc_q <= branch_taken ? branch_target : pc_seq;
        end
    end

    // IR captures fetched data only on a FETCH-state ack.
    always_ff @(posedge clock) begin
        if (reset) begin
            ir_q <= XLEN'(NOP_INSN);
        end else if (ack_hit) begin
            ir_q <= insn_rdata;
        end
    end

    // Strobes are decoded from state and gated by reset so nothing leaks
    // out during the reset cycle.
    assign insn_req        = in_fetch & ~reset;
    assign insn_addr       = pc_q;
    assign pc              = pc_q;
    assign insn_reg        = ir_q;
    assign retire          = commit & ~reset;
    assign rd_write_strobe = commit & exec_rd_enable_write & ~reset;
    assign halted          = (state == HALTED) & ~reset;
    assign fault           = (state == FAULT) & ~reset;

endmodule

// File: tb/tb_insn_sequencer.sv
// Randomized scoreboard bench for insn_sequencer: a driver plays the
// instruction memory and exec unit, a PC model predicts fetches and
// retirements, and a negedge monitor checks them as they appear.
module tb_insn_sequencer;

    localparam int          XLEN = 32;
    localparam logic [31:0] RPC  = 32'h0000_0000;
    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam int          TMO  = 6;   // main DUT watchdog
    localparam int          TMO2 = 4;   // small-timeout instance

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        insn_req;
    logic [31:0] insn_addr;
    logic        insn_ack = 1'b0;
    logic [31:0] insn_rdata = '0;
    logic [31:0] insn_reg;
    logic [31:0] pc;
    logic        exec_rd_enable_write = 1'b0;
    logic        rd_write_strobe;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        halt = 1'b0;
    logic        halted;
    logic        retire;
    logic        fault;

    // second instance, watchdog limit 4
    logic        t_reset = 1'b1;
    logic        t_ack = 1'b0;
    logic [31:0] t_rdata = 32'hCAFE_0001;
    logic        t_zero = 1'b0;
    logic [31:0] t_zero32 = '0;
    logic        t_req, t_strobe, t_halted, t_retire, t_fault;
    logic [31:0] t_addr, t_ir, t_pc;

    always #5 clock = ~clock;

    insn_sequencer #(.XLEN(XLEN), .RESET_PC(RPC), .ACK_TIMEOUT(TMO)) dut (
        .clock(clock), .reset(reset), .insn_req(insn_req), .insn_addr(insn_addr),
        .insn_ack(insn_ack), .insn_rdata(insn_rdata), .insn_reg(insn_reg), .pc(pc),
        .exec_rd_enable_write(exec_rd_enable_write), .rd_write_strobe(rd_write_strobe),
        .branch_taken(branch_taken), .branch_target(branch_target), .halt(halt),
        .halted(halted), .retire(retire), .fault(fault)
    );

    insn_sequencer #(.XLEN(XLEN), .RESET_PC(RPC), .ACK_TIMEOUT(TMO2)) dut_tmo (
        .clock(clock), .reset(t_reset), .insn_req(t_req), .insn_addr(t_addr),
        .insn_ack(t_ack), .insn_rdata(t_rdata), .insn_reg(t_ir), .pc(t_pc),
        .exec_rd_enable_write(t_zero), .rd_write_strobe(t_strobe),
        .branch_taken(t_zero), .branch_target(t_zero32), .halt(t_zero),
        .halted(t_halted), .retire(t_retire), .fault(t_fault)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] insn;
        logic        we;
    } ret_t;

    ret_t        rq[$];   // expected retirements
    logic [31:0] fq[$];   // expected fetch addresses
    int          lq[$];   // expected wait cycles per fetch
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] m_pc = RPC;

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic miss(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: event seen with nothing expected at %0t", nm, $time);
    endtask

    // Monitor: pops expectations whenever a fetch completes or an
    // instruction retires.
    initial begin
        int          run;
        logic [31:0] run_addr;
        logic        run_stable;
        logic [31:0] ea;
        int          el;
        ret_t        er;
        run = 0;
        run_addr = '0;
        run_stable = 1'b1;
        forever begin
            @(negedge clock);
            if (insn_req) begin
                if (run == 0) begin
                    run_addr   = insn_addr;
                    run_stable = 1'b1;
                end else if (insn_addr !== run_addr) begin
                    run_stable = 1'b0;
                end
                run++;
                if (insn_ack) begin
                    if (fq.size() == 0 || lq.size() == 0) begin
                        miss("fetch_unexpected");
                    end else begin
                        ea = fq.pop_front();
                        el = lq.pop_front();
                        chk32("fetch_addr", insn_addr, ea);
                        chk32("fetch_len", 32'(run), 32'(el + 1));
                        chk1("fetch_addr_stable", run_stable, 1'b1);
                    end
                    run = 0;
                end
            end else begin
                run = 0;
            end
            if (rd_write_strobe && !retire) miss("strobe_without_retire");
            if (retire) begin
                if (rq.size() == 0) begin
                    miss("retire_unexpected");
                end else begin
                    er = rq.pop_front();
                    chk32("ret_pc", pc, er.pc);
                    chk32("ret_insn", insn_reg, er.insn);
                    chk1("ret_strobe", rd_write_strobe, er.we);
                end
            end
        end
    end

    // Reset for cyc edges, checking strobes are low and PC/IR reload.
    task automatic do_reset(input int cyc);
        reset = 1'b1;
        insn_ack = 1'($urandom_range(0, 1));
        halt = 1'($urandom_range(0, 1));
        exec_rd_enable_write = 1'($urandom_range(0, 1));
        #1;
        chk1("rst_req", insn_req, 1'b0);
        chk1("rst_retire", retire, 1'b0);
        chk1("rst_strobe", rd_write_strobe, 1'b0);
        chk1("rst_halted", halted, 1'b0);
        chk1("rst_fault", fault, 1'b0);
        repeat (cyc) @(posedge clock);
        #1;
        chk32("rst_pc", pc, RPC);
        chk32("rst_ir", insn_reg, NOP);
        reset = 1'b0;
        insn_ack = 1'b0;
        halt = 1'b0;
        branch_taken = 1'b0;
        #1;
        chk1("rst_fetch_req", insn_req, 1'b1);
        chk32("rst_fetch_addr", insn_addr, RPC);
        m_pc = RPC;
    endtask

    // One instruction: w wait cycles then ack, DECODE, EXECUTE, optional park.
    task automatic do_insn(input int w, input logic [31:0] rd, input logic we,
                           input logic br, input logic [31:0] tgt,
                           input logic hlt, input int hold);
        logic bad;
        bad = br && (tgt[1:0] != 2'b00);
        fq.push_back(m_pc);
        lq.push_back(w);
        if (!bad) rq.push_back('{pc: m_pc, insn: rd, we: we});
        exec_rd_enable_write = we;
        branch_taken = br;
        branch_target = tgt;
        for (int k = 0; k <= w; k++) begin
            insn_ack = (k == w);
            insn_rdata = (k == w) ? rd : $urandom;
            halt = 1'($urandom_range(0, 1));
            #1;
            chk1("fetch_req", insn_req, 1'b1);
            chk1("fetch_retire", retire, 1'b0);
            chk1("fetch_fault", fault, 1'b0);
            @(posedge clock);
            #1;
        end
        // DECODE: stray acks and halt must be ignored
        insn_ack = 1'($urandom_range(0, 1));
        insn_rdata = $urandom;
        halt = 1'($urandom_range(0, 1));
        #1;
        chk1("dec_req", insn_req, 1'b0);
        chk32("dec_ir", insn_reg, rd);
        chk1("dec_retire", retire, 1'b0);
        chk1("dec_strobe", rd_write_strobe, 1'b0);
        @(posedge clock);
        #1;
        // EXECUTE
        halt = hlt;
        insn_ack = 1'($urandom_range(0, 1));
        #1;
        chk1("ex_retire", retire, !bad);
        chk1("ex_strobe", rd_write_strobe, we && !bad);
        chk1("ex_req", insn_req, 1'b0);
        @(posedge clock);
        #1;
        insn_ack = 1'b0;
        if (bad) begin
            #1;
            chk1("bad_fault", fault, 1'b1);
            chk32("bad_pc_held", pc, m_pc);
            chk1("bad_retire", retire, 1'b0);
            chk1("bad_req", insn_req, 1'b0);
        end else begin
            m_pc = br ? tgt : m_pc + 32'd4;
            if (hlt) begin
                for (int k = 0; k < hold; k++) begin
                    insn_ack = 1'($urandom_range(0, 1));
                    #1;
                    chk1("hlt_halted", halted, 1'b1);
                    chk1("hlt_req", insn_req, 1'b0);
                    chk32("hlt_pc", pc, m_pc);
                    if (k == hold - 1) halt = 1'b0;
                    @(posedge clock);
                    #1;
                end
                insn_ack = 1'b0;
            end
            #1;
            chk1("next_halted", halted, 1'b0);
            chk1("next_req", insn_req, 1'b1);
            chk32("next_addr", insn_addr, m_pc);
        end
        branch_taken = 1'b0;
        halt = 1'b0;
    endtask

    // Ack never arrives: FAULT after TMO request cycles, then sticky.
    task automatic do_timeout();
        for (int k = 0; k < TMO; k++) begin
            insn_ack = 1'b0;
            halt = 1'($urandom_range(0, 1));
            #1;
            chk1("tmo_req", insn_req, 1'b1);
            chk1("tmo_fault_early", fault, 1'b0);
            @(posedge clock);
            #1;
        end
        insn_ack = 1'b1;
        #1;
        chk1("tmo_fault", fault, 1'b1);
        chk1("tmo_req_off", insn_req, 1'b0);
        @(posedge clock);
        #1;
        insn_ack = 1'b0;
        chk1("tmo_fault_sticky", fault, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          ev, w, hold;
        logic [31:0] rd, tgt;
        logic        we, br, hlt;

        @(posedge clock);
        #1;

        // ---- small-timeout instance: no ack, then ack in last cycle ----
        t_reset = 1'b0;
        t_ack = 1'b0;
        for (int k = 0; k < TMO2; k++) begin
            #1;
            chk1("t_req", t_req, 1'b1);
            chk1("t_fault_early", t_fault, 1'b0);
            @(posedge clock);
            #1;
        end
        chk1("t_fault", t_fault, 1'b1);
        chk1("t_req_off", t_req, 1'b0);
        t_ack = 1'b1;
        repeat (3) begin
            @(posedge clock);
            #1;
            chk1("t_fault_sticky", t_fault, 1'b1);
        end
        t_reset = 1'b1;
        t_ack = 1'b0;
        #1;
        chk1("t_rst_fault", t_fault, 1'b0);
        @(posedge clock);
        #1;
        t_reset = 1'b0;
        for (int k = 0; k < TMO2; k++) begin
            t_ack = (k == TMO2 - 1);
            #1;
            chk1("t_req_b", t_req, 1'b1);
            chk1("t_fault_b", t_fault, 1'b0);
            @(posedge clock);
            #1;
        end
        t_ack = 1'b0;
        #1;
        chk1("t_nofault", t_fault, 1'b0);
        chk1("t_decode_req", t_req, 1'b0);
        chk32("t_ir", t_ir, 32'hCAFE_0001);

        // ---- main DUT directed sequence ----
        do_reset(2);
        do_insn(0, 32'h1111_0001, 1'b1, 1'b0, 32'h0, 1'b0, 1);   // pc 0
        do_insn(0, 32'h1111_0002, 1'b1, 1'b0, 32'h0, 1'b0, 1);   // pc 4
        do_insn(0, 32'h1111_0003, 1'b1, 1'b0, 32'h0, 1'b1, 3);   // pc 8, park
        chk32("after_halt_pc", m_pc, pc);
        do_insn(5, 32'h2222_0005, 1'b0, 1'b0, 32'h0, 1'b0, 1);   // 5 waits at 12
        do_insn(1, 32'h3333_0000, 1'b1, 1'b1, 32'h100, 1'b0, 1); // branch 0x100
        do_insn(0, 32'h3333_0001, 1'b1, 1'b1, 32'h102, 1'b0, 1); // misaligned
        do_reset(2);
        do_insn(2, 32'h4444_0000, 1'b1, 1'b0, 32'h0, 1'b0, 1);
        // reset in the 2nd wait cycle of the next fetch, then a fresh fetch
        insn_ack = 1'b0;
        @(posedge clock);
        #1;
        do_reset(1);
        do_insn(0, 32'h5555_0000, 1'b1, 1'b0, 32'h0, 1'b0, 1);
        do_timeout();
        do_reset(2);

        // ---- randomized traffic ----
        for (int i = 0; i < 200; i++) begin
            ev   = $urandom_range(0, 99);
            w    = $urandom_range(0, TMO - 1);
            rd   = $urandom;
            we   = 1'($urandom_range(0, 1));
            tgt  = $urandom;
            hold = $urandom_range(1, 3);
            br   = 1'b0;
            hlt  = 1'b0;
            if (ev < 3) begin
                do_timeout();
                do_reset(2);
            end else if (ev < 6) begin
                insn_ack = 1'b0;
                @(posedge clock);
                #1;
                do_reset(1);
            end else begin
                if (ev < 30) begin
                    br  = 1'b1;
                    tgt = (ev < 10) ? 32'hFFFF_FFFC : (tgt & 32'hFFFF_FFFC);
                end else if (ev < 34) begin
                    br  = 1'b1;
                    tgt = (tgt & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3));
                end
                if (ev >= 80) hlt = 1'b1;
                do_insn(w, rd, we, br, tgt, hlt, hold);
                if (br && tgt[1:0] != 2'b00) do_reset(2);
            end
        end

        @(negedge clock);
        @(negedge clock);
        chk32("fetch_q_drained", 32'(fq.size()), 32'd0);
        chk32("retire_q_drained", 32'(rq.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
